bus_mem_responder: RTL and testbench

Bus responder (slave) for the CPU's single-master memory bus: decodes an address window, services one read or write per handshake from an on-chip word-organised SRAM, and returns a single-cycle acknowledge after a programmable number of wait states. It sits on the far side of the bus from the CPU memory stage. It answers the `b_addr/b_data/b_read/b_write/b_ack` handshake that stage drives, and it determines how long the pipeline's `stall_mem` stays asserted.

---
 rtl/bus_mem_responder_pkg.sv | 18 +
 rtl/bus_sram_array.sv | 24 ++
 rtl/bus_mem_responder.sv | 129 ++++++++++++
 tb/tb_bus_mem_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_mem_responder_pkg.sv
// Shared types for the memory-bus responder: FSM states, transaction kind
// and the wait-state ceiling imposed by the 4-bit counter.
package bus_definitions;

   typedef enum logic [1:0] {
      BUS_IDLE,
      BUS_WAIT,
      BUS_ACK
   } bus_state_t;

   typedef enum logic {
      BUS_RD,
      BUS_WR
   } bus_kind_t;

   localparam int BUS_MAX_WAIT = 15;

endpackage

// File: rtl/bus_sram_array.sv
// Synchronous single-port word RAM. rdata only changes on a read strobe, so it
// keeps the last read word while writes or idle cycles go by.
module bus_sram_array #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 10
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] idx,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we)
         mem[idx] <= wdata;
      else if (re)
         rdata <= mem[idx];
   end

endmodule

// File: rtl/bus_mem_responder.sv
// Bus slave over an on-chip SRAM window: address decode, request latching,
// programmable wait states and a single-cycle registered acknowledge.
module bus_mem_responder
   import bus_definitions::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] b_addr_i,
   input  logic [31:0] b_data_i,
   output logic [31:0] b_data_o,
   input  logic        b_read_i,
   input  logic        b_write_i,
   output logic        b_ack_o
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   if (WAIT_CYCLES < 0 || WAIT_CYCLES > BUS_MAX_WAIT) begin : g_bad_wait
      $error("WAIT_CYCLES out of range 0..15");
   end
   if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
      $error("DEPTH_WORDS must be a power of two >= 2");
   end
   if (BASE_ADDR[AW+1:0] != '0) begin : g_bad_base
      $error("BASE_ADDR not aligned to the window size");
   end

   bus_state_t    state, state_nx;
   logic [3:0]    cnt, cnt_nx;
   logic [AW-1:0] idx_q, idx_cur;
   logic [31:0]   wdata_q, wdata_cur;
   bus_kind_t     kind_q, kind_in, kind_cur;
   logic          req, hit, capture, enter_ack;
   logic          we, re, rd_vld;
   logic [31:0]   rdata;
   logic          unused_lsb;

   assign unused_lsb = ^b_addr_i[1:0];
   assign req        = b_read_i | b_write_i;
   assign hit        = (b_addr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
   assign kind_in    = b_write_i ? BUS_WR : BUS_RD;

   // With zero wait states the RAM is accessed on the capture edge, so the
   // live inputs stand in for the not-yet-loaded latches.
   assign idx_cur   = (state == BUS_IDLE) ? b_addr_i[AW+1:2] : idx_q;
   assign wdata_cur = (state == BUS_IDLE) ? b_data_i         : wdata_q;
   assign kind_cur  = (state == BUS_IDLE) ? kind_in          : kind_q;

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      capture   = 1'b0;
      enter_ack = 1'b0;
      case (state)
         BUS_IDLE: begin
            if (req && hit) begin
               capture = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_nx  = BUS_ACK;
                  enter_ack = 1'b1;
               end else begin
                  state_nx = BUS_WAIT;
                  cnt_nx   = WAIT_LOAD;
               end
            end
         end
         BUS_WAIT: begin
            if (!req) begin
               state_nx = BUS_IDLE;
               cnt_nx   = 4'd0;
            end else if (cnt == 4'd0) begin
               state_nx  = BUS_ACK;
               enter_ack = 1'b1;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         BUS_ACK:  state_nx = BUS_IDLE;
         default:  state_nx = BUS_IDLE;
      endcase
   end

   assign we = enter_ack && (kind_cur == BUS_WR);
   assign re = enter_ack && (kind_cur == BUS_RD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= BUS_IDLE;
         cnt     <= 4'd0;
         idx_q   <= '0;
         wdata_q <= 32'h0;
         kind_q  <= BUS_RD;
         b_ack_o <= 1'b0;
         rd_vld  <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         b_ack_o <= enter_ack;
         if (capture) begin
            idx_q   <= b_addr_i[AW+1:2];
            wdata_q <= b_data_i;
            kind_q  <= kind_in;
         end
         if (re)
            rd_vld <= 1'b1;
      end
   end

   // The RAM output register has no reset; rd_vld provides the zero after reset.
   assign b_data_o = rd_vld ? rdata : 32'h0;

   bus_sram_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_sram (
      .clk   (clk),
      .we    (we),
      .re    (re),
      .idx   (idx_cur),
      .wdata (wdata_cur),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_bus_mem_responder.sv
// Bench for bus_mem_responder: four instances with different wait counts,
// a transaction-level reference model and directed handshake sequences.
module tb_bus_mem_responder;

   localparam int N = 4;

   function automatic int wait_of(input int g);
      case (g)
         0:       return 1;
         1:       return 0;
         2:       return 3;
         default: return 5;
      endcase
   endfunction

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] addr [N];
   logic [31:0] wdat [N];
   logic [31:0] rdat [N];
   logic        rd   [N];
   logic        wr   [N];
   logic        ack  [N];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      bus_mem_responder #(
         .BASE_ADDR   (32'h0000_0000),
         .DEPTH_WORDS (1024),
         .WAIT_CYCLES (wait_of(g))
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .b_addr_i  (addr[g]),
         .b_data_i  (wdat[g]),
         .b_data_o  (rdat[g]),
         .b_read_i  (rd[g]),
         .b_write_i (wr[g]),
         .b_ack_o   (ack[g])
      );
   end

   // Reference model: a transaction is captured on a hit, must survive
   // wait_of(i) further cycles of request, and then acks for one cycle.
   logic [31:0] m_mem [N][1024];
   logic [31:0] m_data [N];
   logic [31:0] c_data [N];
   bit          m_busy [N];
   bit          m_ack  [N];
   bit          c_wr   [N];
   int          c_idx  [N];
   int          m_left [N];
   int          ack_cnt [N];

   initial begin
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < 1024; k++) m_mem[i][k] = 32'h0;
         ack_cnt[i] = 0;
      end
   end

   function automatic void finish_txn(input int i);
      m_ack[i] = 1'b1;
      if (c_wr[i]) m_mem[i][c_idx[i]] = c_data[i];
      else         m_data[i] = m_mem[i][c_idx[i]];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            m_busy[i] = 1'b0;
            m_ack[i]  = 1'b0;
            m_data[i] = 32'h0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (m_ack[i]) begin
               m_ack[i] = 1'b0;
            end else if (!m_busy[i]) begin
               if ((rd[i] || wr[i]) && addr[i] < 32'h1000) begin
                  c_wr[i]   = wr[i];
                  c_idx[i]  = int'(addr[i]) / 4;
                  c_data[i] = wdat[i];
                  if (wait_of(i) == 0) finish_txn(i);
                  else begin
                     m_busy[i] = 1'b1;
                     m_left[i] = wait_of(i);
                  end
               end
            end else if (!(rd[i] || wr[i])) begin
               m_busy[i] = 1'b0;
            end else begin
               m_left[i] = m_left[i] - 1;
               if (m_left[i] == 0) begin
                  m_busy[i] = 1'b0;
                  finish_txn(i);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < N; i++) begin
            checks++;
            if (ack[i] !== m_ack[i] || rdat[i] !== m_data[i]) begin
               errors++;
               $display("FAIL model_cmp inst%0d t=%0t: ack=%b data=%h, expected ack=%b data=%h",
                        i, $time, ack[i], rdat[i], m_ack[i], m_data[i]);
            end
            if (ack[i] === 1'b1) ack_cnt[i]++;
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Present a request (caller is just after a rising edge), wait for the
   // ack, report the cycle it came in and the data seen, then drop it.
   task automatic txn(input int i, input logic [31:0] a, input logic [31:0] d,
                      input bit r, input bit w, output int at, output logic [31:0] q);
      addr[i] = a; wdat[i] = d; rd[i] = r; wr[i] = w;
      at = -1; q = 32'hx;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (ack[i] === 1'b1) begin
            at = n; q = rdat[i];
            break;
         end
      end
      @(posedge clk); #1;
      rd[i] = 1'b0; wr[i] = 1'b0;
      if (at < 0) begin
         errors++;
         $display("FAIL txn_timeout inst%0d addr=%h: got no ack, expected one within 40 cycles", i, a);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int          at;
   logic [31:0] q;
   int          base, nack;

   initial begin
      for (int i = 0; i < N; i++) begin
         addr[i] = 32'h0; wdat[i] = 32'h0; rd[i] = 1'b0; wr[i] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(1);
      check("reset_ack", {31'h0, ack[0]}, 32'h0);
      check("reset_data", rdat[0], 32'h0);

      // write then read, one wait state
      txn(0, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, at, q);
      check("wr_ack_cycle", at, 2);
      txn(0, 32'h10, 32'h0, 1'b1, 1'b0, at, q);
      check("rd_ack_cycle", at, 2);
      check("rd_data", q, 32'hDEAD_BEEF);
      txn(0, 32'h12, 32'h0, 1'b1, 1'b0, at, q);
      check("rd_lowbits_data", q, 32'hDEAD_BEEF);

      // out-of-window read held for 20 cycles
      addr[0] = 32'h0001_0000; rd[0] = 1'b1; nack = 0;
      repeat (20) begin
         @(negedge clk);
         if (ack[0] === 1'b1) nack++;
      end
      @(posedge clk); #1 rd[0] = 1'b0;
      check("miss_no_ack", nack, 0);
      check("miss_data_held", rdat[0], 32'hDEAD_BEEF);

      // back-to-back with zero wait states
      base = ack_cnt[1];
      txn(1, 32'h4, 32'h1, 1'b0, 1'b1, at, q);
      check("b2b_wr_cycle", at, 1);
      txn(1, 32'h4, 32'h0, 1'b1, 1'b0, at, q);
      check("b2b_rd_cycle", at + 2, 3);
      check("b2b_rd_data", q, 32'h1);
      idle(4);
      check("b2b_ack_count", ack_cnt[1] - base, 2);

      // aborted write leaves old contents
      txn(2, 32'h8, 32'h55, 1'b0, 1'b1, at, q);
      check("w3_wr_cycle", at, 4);
      base = ack_cnt[2];
      addr[2] = 32'h8; wdat[2] = 32'h99; wr[2] = 1'b1;
      idle(2);
      wr[2] = 1'b0;
      idle(8);
      check("abort_no_ack", ack_cnt[2] - base, 0);
      txn(2, 32'h8, 32'h0, 1'b1, 1'b0, at, q);
      check("abort_old_value", q, 32'h55);

      // read and write together: the write wins
      base = ack_cnt[0];
      txn(0, 32'hC, 32'h7, 1'b1, 1'b1, at, q);
      idle(3);
      check("rw_single_ack", ack_cnt[0] - base, 1);
      txn(0, 32'hC, 32'h0, 1'b1, 1'b0, at, q);
      check("rw_readback", q, 32'h7);

      // reset in the middle of a 5-wait write
      txn(3, 32'h20, 32'hA5, 1'b0, 1'b1, at, q);
      check("w5_wr_cycle", at, 6);
      txn(3, 32'h20, 32'h0, 1'b1, 1'b0, at, q);
      check("w5_rd_data", q, 32'hA5);
      addr[3] = 32'h20; wdat[3] = 32'h1234; wr[3] = 1'b1;
      idle(2);
      rst_n = 1'b0;
      #1;
      check("rst_async_ack", {31'h0, ack[3]}, 32'h0);
      check("rst_async_data", rdat[3], 32'h0);
      check("rst_async_data_other", rdat[0], 32'h0);
      @(posedge clk); #1;
      wr[3] = 1'b0;
      rst_n = 1'b1;
      idle(1);
      txn(3, 32'h20, 32'h0, 1'b1, 1'b0, at, q);
      check("post_rst_cycle", at, 6);
      check("post_rst_unchanged", q, 32'hA5);

      idle(3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within 200000 time units");
      $fatal(1, "watchdog");
   end

endmodule
